// File: rtl/aes_package.sv
// Shared AES constants, decrypt FSM state type and GF(2^8) helpers.
package aes_package;

  localparam int BYTE                 = 8;
  localparam int WORD_SIZE            = 32;
  localparam int DATA_WIDTH           = 128;
  localparam int NUM_OF_ROUNDS        = 10;
  localparam int EXPANSIONED_KEY_SIZE = DATA_WIDTH * (NUM_OF_ROUNDS + 1);
  localparam int MAT_NUM_ROW          = 4;
  localparam int MAT_NUM_COLUMN       = 4;

  localparam logic [7:0] AES_POLY = 8'h1B;

  // InvMixColumns circulant row {0e, 0b, 0d, 09}, one nibble per coefficient
  localparam logic [15:0] INV_MIX_COEFFS = 16'hEBD9;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } aes_dec_state_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by a coefficient of at most 4 bits (all InvMixColumns terms fit)
  function automatic logic [7:0] gf_mul4(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) acc = acc ^ p;
      p = gf_xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: purely combinational 256-entry lookup.
module aes_inv_sbox
  import aes_package::*;
(
  input  logic [BYTE-1:0] value,
  output logic [BYTE-1:0] inv_value
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign inv_value = INV_SBOX[value];

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Define AES_DEC_HANDSHAKE_EN to hold the result until out_ready is seen.
module aes_decrypt_core
  import aes_package::*;
#(
  parameter int NUM_ROUNDS = NUM_OF_ROUNDS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           cipher_text,
  input  logic [EXPANSIONED_KEY_SIZE-1:0] expanded_key,
  output logic                            out_valid,
`ifdef AES_DEC_HANDSHAKE_EN
  input  logic                            out_ready,
`endif
  output logic [DATA_WIDTH-1:0]           plain_text
);

  localparam int NUM_BYTES = MAT_NUM_ROW * MAT_NUM_COLUMN;

  aes_dec_state_t        fsm_reg, fsm_next;
  logic [DATA_WIDTH-1:0] state_reg, state_next;
  logic [3:0]            round_cnt_reg, round_cnt_next;

  logic [DATA_WIDTH-1:0] round_keys [16];
  logic [DATA_WIDTH-1:0] sub_state;
  logic [DATA_WIDTH-1:0] ark_state;
  logic [DATA_WIDTH-1:0] imc_state;

  // Round key r is words w[4r]..w[4r+3] with w[4r] landing in the top bits
  for (genvar gi = 0; gi < 16; gi++) begin : g_round_key
    if (gi <= NUM_ROUNDS) begin : g_used
      assign round_keys[gi] = {expanded_key[(4*gi)*WORD_SIZE   +: WORD_SIZE],
                               expanded_key[(4*gi+1)*WORD_SIZE +: WORD_SIZE],
                               expanded_key[(4*gi+2)*WORD_SIZE +: WORD_SIZE],
                               expanded_key[(4*gi+3)*WORD_SIZE +: WORD_SIZE]};
    end else begin : g_unused
      assign round_keys[gi] = '0;
    end
  end

  // InvShiftRows is pure wiring folded into the S-box input selection
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_inv_sub
    localparam int ROW = gi % MAT_NUM_ROW;
    localparam int COL = gi / MAT_NUM_ROW;
    localparam int SRC = ((COL + MAT_NUM_COLUMN - ROW) % MAT_NUM_COLUMN) * MAT_NUM_ROW + ROW;
    aes_inv_sbox u_inv_sbox (
      .value     (state_reg[DATA_WIDTH-1-BYTE*SRC -: BYTE]),
      .inv_value (sub_state[DATA_WIDTH-1-BYTE*gi -: BYTE])
    );
  end

  assign ark_state = sub_state ^ round_keys[round_cnt_reg];

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_inv_mix
    localparam int ROW  = gi % MAT_NUM_ROW;
    localparam int BASE = (gi / MAT_NUM_ROW) * MAT_NUM_ROW;
    localparam logic [3:0] K0 = INV_MIX_COEFFS[15-4*((0 + MAT_NUM_ROW - ROW) % MAT_NUM_ROW) -: 4];
    localparam logic [3:0] K1 = INV_MIX_COEFFS[15-4*((1 + MAT_NUM_ROW - ROW) % MAT_NUM_ROW) -: 4];
    localparam logic [3:0] K2 = INV_MIX_COEFFS[15-4*((2 + MAT_NUM_ROW - ROW) % MAT_NUM_ROW) -: 4];
    localparam logic [3:0] K3 = INV_MIX_COEFFS[15-4*((3 + MAT_NUM_ROW - ROW) % MAT_NUM_ROW) -: 4];
    assign imc_state[DATA_WIDTH-1-BYTE*gi -: BYTE] =
        gf_mul4(ark_state[DATA_WIDTH-1-BYTE*(BASE+0) -: BYTE], K0) ^
        gf_mul4(ark_state[DATA_WIDTH-1-BYTE*(BASE+1) -: BYTE], K1) ^
        gf_mul4(ark_state[DATA_WIDTH-1-BYTE*(BASE+2) -: BYTE], K2) ^
        gf_mul4(ark_state[DATA_WIDTH-1-BYTE*(BASE+3) -: BYTE], K3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg       <= IDLE;
      state_reg     <= '0;
      round_cnt_reg <= '0;
    end else begin
      fsm_reg       <= fsm_next;
      state_reg     <= state_next;
      round_cnt_reg <= round_cnt_next;
    end
  end

  always_comb begin
    fsm_next       = fsm_reg;
    state_next     = state_reg;
    round_cnt_next = round_cnt_reg;
    case (fsm_reg)
      IDLE: begin
        if (in_valid) begin
          state_next     = cipher_text ^ round_keys[NUM_ROUNDS];
          round_cnt_next = 4'(NUM_ROUNDS - 1);
          fsm_next       = ROUND;
        end
      end
      ROUND: begin
        if (round_cnt_reg == 4'd0) begin
          state_next = ark_state;
          fsm_next   = DONE;
        end else begin
          state_next     = imc_state;
          round_cnt_next = round_cnt_reg - 4'd1;
        end
      end
      DONE: begin
`ifdef AES_DEC_HANDSHAKE_EN
        if (out_ready) fsm_next = IDLE;
`else
        fsm_next = IDLE;
`endif
      end
      default: fsm_next = IDLE;
    endcase
  end

  assign in_ready   = (fsm_reg == IDLE);
  assign out_valid  = (fsm_reg == DONE);
  assign plain_text = state_reg;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Scoreboard bench for aes_decrypt_core: a forward-cipher reference model
// produces ciphertexts for random plaintexts; a monitor checks each result.
module tb_aes_decrypt_core;

  typedef struct {
    logic [127:0] pt;
    int           acc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [127:0]   cipher_text = '0;
  logic [1407:0]  expanded_key = '0;
  logic           out_valid;
  logic [127:0]   plain_text;
`ifdef AES_DEC_HANDSHAKE_EN
  logic           out_ready = 1'b1;
`endif

  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  int             out_episodes = 0;
  logic [127:0]   exp_pt = '0;
  exp_t           sb_q[$];
  logic [7:0]     sbox_m [256];

  logic           prev_valid = 1'b0;
  logic           prev_ready = 1'b0;
  logic [127:0]   held_pt = '0;

  aes_decrypt_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .cipher_text  (cipher_text),
    .expanded_key (expanded_key),
    .out_valid    (out_valid),
`ifdef AES_DEC_HANDSHAKE_EN
    .out_ready    (out_ready),
`endif
    .plain_text   (plain_text)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model (FIPS-197 forward cipher) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r1, r2, r3, r4;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
      sbox_m[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] ek;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    ek = '0;
    for (int i = 0; i < 44; i++) ek[32*i +: 32] = w[i];
    return ek;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] ek);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] ct;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ ek[32*(k/4) + 31 - 8*(k%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox_m[s[k]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
      s = t;
      if (r < 10) begin
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++)
            t[4*c+row] = gmul(s[4*c+row], 8'h02) ^ gmul(s[4*c+(row+1)%4], 8'h03) ^
                         s[4*c+(row+2)%4] ^ s[4*c+(row+3)%4];
        s = t;
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ ek[32*(4*r + k/4) + 31 - 8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) ct[127-8*k -: 8] = s[k];
    return ct;
  endfunction

  // ---------------- acceptance monitor: push expectation ----------------
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && in_valid && in_ready) begin
      e.pt  = exp_pt;
      e.acc = cyc + 1;
      sb_q.push_back(e);
    end
  end

  // ---------------- output monitor: pop and compare ----------------
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_plain_text", plain_text, 128'(0));
      prev_valid = 1'b0;
    end else begin
      if (prev_valid) begin
        if (prev_ready) begin
          check("done_left", 128'(out_valid), 128'(0));
          check("in_ready_after_done", 128'(in_ready), 128'(1));
        end else begin
          check("out_valid_held", 128'(out_valid), 128'(1));
          check("plain_text_held", plain_text, held_pt);
        end
      end else if (out_valid) begin
        out_episodes++;
        if (sb_q.size() == 0) begin
          check("unexpected_out_valid", 128'(out_valid), 128'(0));
        end else begin
          e = sb_q.pop_front();
          held_pt = e.pt;
          check("plain_text", plain_text, e.pt);
          check("latency", 128'(cyc), 128'(e.acc + 10));
        end
      end
      prev_valid = out_valid;
`ifdef AES_DEC_HANDSHAKE_EN
      prev_ready = out_ready;
`else
      prev_ready = 1'b1;
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic wait_accept(output int acc);
    int n;
    n = 0;
    acc = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 60);
    if (in_ready) acc = cyc + 1;
    else check("accept_timeout", 128'(in_ready), 128'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 128'(sb_q.size()), 128'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic send_block(input logic [127:0] ct, input logic [1407:0] ek, input logic [127:0] pt);
    int acc;
    @(posedge clk);
    #1;
    cipher_text  = ct;
    expanded_key = ek;
    exp_pt       = pt;
    in_valid     = 1'b1;
    wait_accept(acc);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0]  key, pt, pt2;
    logic [1407:0] ek;
    int            a1, a2, ep0, n;

    build_sbox();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_out_valid", 128'(out_valid), 128'(0));

    // FIPS-197 C.1 and appendix B
    send_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, expand(128'h000102030405060708090a0b0c0d0e0f),
               128'h00112233445566778899aabbccddeeff);
    drain();
    send_block(128'h3925841d02dc09fbdc118597196a0b32, expand(128'h2b7e151628aed2a6abf7158809cf4f3c),
               128'h3243f6a8885a308d313198a2e0370734);
    drain();

    // random keys and plaintexts through the forward model
    for (int i = 0; i < 8; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      ek  = expand(key);
      send_block(encrypt(pt, ek), ek, pt);
      drain();
    end

    // in_valid held high across two blocks sharing one key
    key = {$urandom, $urandom, $urandom, $urandom};
    pt  = {$urandom, $urandom, $urandom, $urandom};
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    ek  = expand(key);
    @(posedge clk);
    #1;
    cipher_text  = encrypt(pt, ek);
    expanded_key = ek;
    exp_pt       = pt;
    in_valid     = 1'b1;
    wait_accept(a1);
    @(posedge clk);
    #1;
    cipher_text = encrypt(pt2, ek);
    exp_pt      = pt2;
    wait_accept(a2);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("second_accept_gap", 128'(a2 - a1), 128'(12));
    drain();

    // reset pulsed mid-decrypt discards the block
    key = {$urandom, $urandom, $urandom, $urandom};
    pt  = {$urandom, $urandom, $urandom, $urandom};
    ek  = expand(key);
    send_block(encrypt(pt, ek), ek, pt);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_plain_text", plain_text, 128'(0));
    check("async_rst_in_ready", 128'(in_ready), 128'(1));
    sb_q.delete();
    ep0 = out_episodes;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 128'(in_ready), 128'(1));
    repeat (15) @(negedge clk);
    check("no_valid_after_rst", 128'(out_episodes), 128'(ep0));
    send_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, expand(128'h000102030405060708090a0b0c0d0e0f),
               128'h00112233445566778899aabbccddeeff);
    drain();

`ifdef AES_DEC_HANDSHAKE_EN
    // consumer stalls for 7 cycles of out_valid
    out_ready = 1'b0;
    send_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, expand(128'h000102030405060708090a0b0c0d0e0f),
               128'h00112233445566778899aabbccddeeff);
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("hs_out_valid_rise", 128'(out_valid), 128'(1));
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      check("hs_hold_valid", 128'(out_valid), 128'(1));
      check("hs_hold_data", plain_text, 128'h00112233445566778899aabbccddeeff);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("hs_valid_until_edge", 128'(out_valid), 128'(1));
    @(negedge clk);
    check("hs_released", 128'(out_valid), 128'(0));
    check("hs_idle_in_ready", 128'(in_ready), 128'(1));
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_decrypt_core.md
AES_DECRYPT_CORE -- requirements
Module: aes_decrypt_core

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default aes_package::NUM_OF_ROUNDS (10), giving the number of inverse cipher rounds; only 10 (AES-128) is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: ciphertext and key are offered.
REQ-005 SHALL have port in_ready, output, 1 bit: core accepts a block; the transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-006 SHALL have port cipher_text, input, DATA_WIDTH (128) bits; byte 0 is bits [127:120], column-major per FIPS-197.
REQ-007 SHALL have port expanded_key, input, EXPANSIONED_KEY_SIZE (1408) bits; word w[i] = bits [32i+31:32i]; round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in bits [127:96].
REQ-008 SHALL have port out_valid, output, 1 bit: plain_text is valid.
REQ-009 SHALL have port plain_text, output, DATA_WIDTH bits, using the same byte order as cipher_text.
REQ-010 SHALL have port out_ready, input, 1 bit, present only when AES_DEC_HANDSHAKE_EN is defined.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, ROUND, DONE.
REQ-012 SHALL assert in_ready only in IDLE.
REQ-013 SHALL, on acceptance in IDLE, load state <= cipher_text ^ round key 10, load round counter <= 9, and go to ROUND.
REQ-014 SHALL, in ROUND with counter r >= 1, apply InvShiftRows, InvSubBytes, AddRoundKey(r), InvMixColumns in one cycle, then decrement r.
REQ-015 SHALL, in ROUND with counter r = 0, apply InvShiftRows, InvSubBytes, AddRoundKey(0) without InvMixColumns, then go to DONE.
REQ-016 SHALL assert out_valid exactly in DONE, which gives a latency of 11 rising edges from the acceptance edge (inclusive) to out_valid high.
REQ-017 SHALL drive plain_text from the state register; plain_text is stable while out_valid is high.
REQ-018 SHALL sample expanded_key combinationally each round and never register it; the source SHALL hold it stable from acceptance until out_valid.
REQ-019 SHALL ignore in_valid outside IDLE; no block is lost or queued.
REQ-020 SHALL use a 4-bit round counter; values above 9 are unreachable.
REQ-021 SHALL implement InvMixColumns in GF(2^8) with polynomial 0x11B, using coefficients 0e, 0b, 0d, 09.

Reset
REQ-022 SHALL, while rst_n is low, force state=IDLE, in_ready=1 (after release), out_valid=0, plain_text=0, and round counter=0, irrespective of clk.
REQ-023 SHALL, on reset assertion mid-ROUND or in DONE, discard the block; no out_valid follows the release.

Configuration
REQ-024 SHALL use macro AES_DEC_HANDSHAKE_EN.
REQ-025 SHALL, with AES_DEC_HANDSHAKE_EN defined, hold DONE (out_valid high, plain_text stable) until out_ready is high at a rising edge, then return to IDLE.
REQ-026 SHALL, without AES_DEC_HANDSHAKE_EN, hold DONE for exactly one cycle (a one-cycle out_valid pulse), then return to IDLE; the out_ready port is absent.
REQ-027 SHALL, in both configurations, begin accepting a new block no earlier than the cycle after DONE is left.

Structure
REQ-028 SHALL take BYTE, WORD_SIZE, DATA_WIDTH, EXPANSIONED_KEY_SIZE, NUM_OF_ROUNDS, MAT_NUM_ROW, and MAT_NUM_COLUMN from aes_package.
REQ-029 SHALL add to aes_package the FSM state typedef aes_dec_state_t (IDLE, ROUND, DONE) and the GF constant AES_POLY = 8'h1B.
REQ-030 SHALL instantiate the combinational sub-module aes_inv_sbox (8-bit in, 8-bit out, 256-entry table) 16 times for InvSubBytes.

Verification
REQ-031 SHALL cover FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, with out_valid high 11 edges after acceptance.
REQ-032 SHALL cover FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
REQ-033 SHALL cover in_valid held high continuously with two blocks: the second block is accepted only after DONE is left, and both plaintexts are correct and in order.
REQ-034 SHALL cover rst_n pulsed low at round 5 -> out_valid never rises, in_ready=1 after release, and the next C.1 block decrypts correctly.
REQ-035 SHALL cover, with AES_DEC_HANDSHAKE_EN defined, out_ready held low for 7 cycles -> out_valid and plain_text held for 7 cycles, with IDLE entered on the edge where out_ready=1.
REQ-036 SHALL cover, without AES_DEC_HANDSHAKE_EN, the C.1 vector -> out_valid high for exactly 1 cycle and in_ready=1 on the next cycle.
